hidden_neuron_mac: RTL and testbench
====================================

# hidden_neuron_mac

Parametrised, sequential successor to the hidden-layer neuron. It computes the weighted sum of `N_IN` binary activations with signed fixed-point weights and a signed bias, one multiply-accumulate term per clock. The result then goes through a selectable activation (ReLU or linear) with saturation to `OUT_W` bits. It sits between the input-feature register and the output-layer neurons, and uses a start/ready/valid handshake so a layer controller can sequence several neurons.

## Interface
Parameters:
- `N_IN`, default 8: number of binary inputs; must be ≥1.
- `W_W`, default 8: weight/bias width, two's complement Q1.(W_W-1).
- `OUT_W`, default 10: result width; must be ≥2. LSB weight is the same as the weight LSB.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: clock enable. When low, the FSM, counter and accumulator hold.
- `start_i`  in  1: request a computation. Accepted only when `ready_o`=1 and `en_i`=1.
- `x_i`  in  `N_IN`: binary activations; bit k selects weight k.
- `w_i`  in  `N_IN*W_W`: weight k at `[k*W_W +: W_W]`, signed.
- `b_i`  in  `W_W`: bias, signed.
- `relu_en_i`  in  1: 1 selects ReLU with unsigned output; 0 selects linear with signed output.
- `ready_o`  out  1: high in IDLE.
- `valid_o`  out  1: one-cycle pulse when a new result is available.
- `neuron_o`  out  `OUT_W`: result; held until the next result is written.
- `ovf_o`  out  1: set if the current `neuron_o` was clamped at a positive limit or the linear negative limit; updated together with `neuron_o`.

## Operation
- FSM states are IDLE, ACC and ACT.
- **IDLE → ACC** on an accepted start.
  - At that edge, `x_i`, `w_i`, `b_i` and `relu_en_i` are captured into internal registers. Inputs may change afterwards.
  - The accumulator is loaded with `b_i` sign-extended, and index k is set to 0.
- **ACC**
  - At each enabled edge, the accumulator adds captured `w[k]` sign-extended if `x[k]`=1, otherwise adds 0. Then k increments.
  - After the edge that processes k=`N_IN`-1, the FSM goes to ACT.
- **ACT → IDLE** at the next enabled edge. At this edge `neuron_o` and `ovf_o` are registered and `valid_o` is set.
- **Accumulator width:** `ACC_W` = `W_W` + clog2(`N_IN`+1). The accumulator never wraps internally.
- **ReLU mode:**
  - acc<0 gives 0 with `ovf_o`=0.
  - acc>2^`OUT_W`-1 gives 2^`OUT_W`-1 with `ovf_o`=1.
  - Otherwise the output is acc with `ovf_o`=0.
- **Linear mode:** the output is acc clamped to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1], in two's complement. `ovf_o`=1 if clamped.
- **`start_i` outside IDLE** is ignored. No queuing.
- **`en_i`=0:** the FSM, k, accumulator and captured operands hold, and `start_i` is ignored. `valid_o` still clears at the next edge; it never stretches.
- **Reset** (asserted at any time, including mid-ACC) forces IDLE, k=0, accumulator=0, `neuron_o`=0, `ovf_o`=0 and `valid_o`=0. `ready_o`=1 while and after reset. A partial computation is discarded and no `valid_o` is produced for it.

## Timing
- With `en_i` held high, call the accept edge E0.
  - ACC edges are E1..E`N_IN`.
  - The ACT edge is E(`N_IN`+1).
  - `valid_o` is high in the cycle following E(`N_IN`+1).
- Latency from accept edge to result is `N_IN`+1 edges.
- `ready_o` and `valid_o` are high in the same cycle. A start held high is accepted at E(`N_IN`+2), so back-to-back throughput is one result per `N_IN`+2 cycles.
- Each cycle with `en_i`=0 during ACC/ACT delays `valid_o` by exactly one cycle.
- `ready_o` is decoded from state registers only; it has no combinational path from inputs.

## Test plan
All scenarios use the defaults: `N_IN`=8, `W_W`=8, `OUT_W`=10.
1. **Nominal sum:** `x_i`=8'hFF, all weights 8'h40, `b_i`=0, ReLU → `neuron_o`=10'd512, `ovf_o`=0, `valid_o` one cycle after E9, `ready_o`=1 at the same time.
2. **Sparse inputs and bias:**
   - `x_i`=8'b0000_0101, w0=w2=8'h7F, others 8'h7F, `b_i`=8'h7F, ReLU → 381.
   - `x_i`=8'h01, w0=8'h80, `b_i`=0: ReLU → 0, `ovf_o`=0; linear → 10'h380.
3. **Saturation:**
   - All x=1, all w=8'h7F, `b_i`=8'h7F (acc=1143): ReLU → 1023 with `ovf_o`=1; linear → 511 with `ovf_o`=1.
   - All w=8'h80, `b_i`=8'h80 (acc=-1152), linear → 10'h200 with `ovf_o`=1.
4. **Handshake:**
   - `start_i` held high for 30 cycles → `valid_o` pulses at 10-cycle spacing.
   - Pulsing `start_i` mid-ACC, and changing `w_i` after accept, has no effect on the result.
5. **Stall:** `en_i`=0 for 3 cycles during ACC → the result is unchanged and `valid_o` arrives exactly 3 cycles later than nominal.
6. **Reset mid-operation:** assert `rst_i` low at E4 → all outputs 0 and `ready_o`=1, with no `valid_o`. After release, a new start yields the scenario 1 result with nominal latency.

Source files
------------

// File: rtl/hidden_neuron_mac_if.sv
// Start/ready/valid bus between a layer controller (master) and one
// sequential hidden-layer neuron (slave).
interface hidden_neuron_mac_if #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned W_W   = 8,
  parameter int unsigned OUT_W = 10
);
  logic                   en;
  logic                   start;
  logic [N_IN-1:0]        x;
  logic [N_IN*W_W-1:0]    w;
  logic [W_W-1:0]         b;
  logic                   relu_en;
  logic                   ready;
  logic                   valid;
  logic [OUT_W-1:0]       neuron;
  logic                   ovf;

  modport master (
    output en, start, x, w, b, relu_en,
    input  ready, valid, neuron, ovf
  );

  modport slave (
    input  en, start, x, w, b, relu_en,
    output ready, valid, neuron, ovf
  );
endinterface

// File: rtl/hidden_neuron_mac.sv
// Sequential hidden-layer neuron: bias plus one weighted binary input per
// clock, then ReLU or linear activation with saturation to OUT_W bits.
module hidden_neuron_mac #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned W_W   = 8,
  parameter int unsigned OUT_W = 10
) (
  input logic               clk_i,
  input logic               rst_i,
  hidden_neuron_mac_if.slave bus
);

  localparam int unsigned ACC_W = W_W + $clog2(N_IN + 1);
  localparam int unsigned K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

  // Saturation limits, widened so every comparison is a plain signed compare
  localparam logic signed [CMP_W-1:0] U_MAX = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [CMP_W-1:0] S_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] S_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, ACT} state_t;

  state_t                   state;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;
  logic [N_IN-1:0]          x_q;
  logic [W_W-1:0]           w_q [N_IN];
  logic                     relu_q;
  logic                     ready_q;
  logic                     valid_q;
  logic [OUT_W-1:0]         neuron_q;
  logic                     ovf_q;

  logic [W_W-1:0]           w_sel_c;
  logic signed [ACC_W-1:0]  term_c;
  logic signed [CMP_W-1:0]  acc_x_c;
  logic [OUT_W-1:0]         sat_val_c;
  logic                     sat_ovf_c;

  assign w_sel_c = w_q[k];
  assign term_c  = x_q[k] ? {{(ACC_W-W_W){w_sel_c[W_W-1]}}, w_sel_c} : '0;
  assign acc_x_c = {{(CMP_W-ACC_W){acc[ACC_W-1]}}, acc};

  // Activation and clamp of the finished sum
  always_comb begin
    sat_val_c = acc_x_c[OUT_W-1:0];
    sat_ovf_c = 1'b0;
    if (relu_q) begin
      if (acc[ACC_W-1]) begin
        sat_val_c = '0;
      end else if (acc_x_c > U_MAX) begin
        sat_val_c = U_MAX[OUT_W-1:0];
        sat_ovf_c = 1'b1;
      end
    end else begin
      if (acc_x_c > S_MAX) begin
        sat_val_c = S_MAX[OUT_W-1:0];
        sat_ovf_c = 1'b1;
      end else if (acc_x_c < S_MIN) begin
        sat_val_c = S_MIN[OUT_W-1:0];
        sat_ovf_c = 1'b1;
      end
    end
  end

  // Control FSM, operand capture, accumulator and result registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      k        <= '0;
      acc      <= '0;
      x_q      <= '0;
      relu_q   <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      neuron_q <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) w_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.en) begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              x_q     <= bus.x;
              relu_q  <= bus.relu_en;
              for (int unsigned i = 0; i < N_IN; i++) w_q[i] <= bus.w[i*W_W +: W_W];
              acc     <= {{(ACC_W-W_W){bus.b[W_W-1]}}, bus.b};
              k       <= '0;
              ready_q <= 1'b0;
              state   <= ACC;
            end
          end
          ACC: begin
            acc <= acc + term_c;
            k   <= k + K_W'(1);
            if (k == K_LAST) state <= ACT;
          end
          ACT: begin
            neuron_q <= sat_val_c;
            ovf_q    <= sat_ovf_c;
            valid_q  <= 1'b1;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
          default: begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.valid  = valid_q;
  assign bus.neuron = neuron_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_hidden_neuron_mac.sv
// Directed + random bench for hidden_neuron_mac with a result scoreboard
// and cycle-accurate latency / throughput checks.
module tb_hidden_neuron_mac;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned W_W   = 8;
  localparam int unsigned OUT_W = 10;

  typedef struct packed {
    logic [OUT_W-1:0] n;
    logic             o;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hidden_neuron_mac_if #(.N_IN(N_IN), .W_W(W_W), .OUT_W(OUT_W)) bus ();

  hidden_neuron_mac #(.N_IN(N_IN), .W_W(W_W), .OUT_W(OUT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vq[$];
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   valid_cnt  = 0;
  int   base_cnt   = 0;
  int   acc_cyc    = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [OUT_W-1:0] n, input logic o);
    exp_t r;
    r.n = n;
    r.o = o;
    return r;
  endfunction

  function automatic logic [N_IN*W_W-1:0] rep(input logic [W_W-1:0] v);
    logic [N_IN*W_W-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*W_W +: W_W] = v;
    return r;
  endfunction

  // Reference: integer sum, then clamp to the selected output range
  function automatic exp_t model(input logic [N_IN-1:0] x, input logic [N_IN*W_W-1:0] w,
                                 input logic [W_W-1:0] b, input logic relu);
    logic signed [W_W-1:0] t;
    int   sum;
    int   umax;
    int   smax;
    int   smin;
    exp_t r;
    umax = (1 << OUT_W) - 1;
    smax = (1 << (OUT_W - 1)) - 1;
    smin = -(1 << (OUT_W - 1));
    t    = b;
    sum  = int'(t);
    for (int k = 0; k < N_IN; k++) begin
      if (x[k]) begin
        t   = w[k*W_W +: W_W];
        sum = sum + int'(t);
      end
    end
    r.o = 1'b0;
    if (relu) begin
      if (sum < 0)         r.n = '0;
      else if (sum > umax) begin r.n = OUT_W'(umax); r.o = 1'b1; end
      else                 r.n = OUT_W'(sum);
    end else begin
      if (sum > smax)      begin r.n = OUT_W'(smax); r.o = 1'b1; end
      else if (sum < smin) begin r.n = OUT_W'(smin); r.o = 1'b1; end
      else                 r.n = OUT_W'(sum);
    end
    return r;
  endfunction

  // Result monitor: pops the scoreboard on every valid pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.valid === 1'b1) begin
      exp_t e;
      valid_cnt++;
      vq.push_back(cyc);
      chk("valid_single_cycle", 32'(prev_valid), 32'd0);
      chk("ready_with_valid", 32'(bus.ready), 32'd1);
      chk("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("neuron", 32'(bus.neuron), 32'(e.n));
        chk("ovf", 32'(bus.ovf), 32'(e.o));
      end
    end
    prev_valid = (bus.valid === 1'b1);
  end

  task automatic start_op(input logic [N_IN-1:0] x, input logic [N_IN*W_W-1:0] w,
                          input logic [W_W-1:0] b, input logic relu, input exp_t e);
    @(negedge clk);
    chk("ready_before_start", 32'(bus.ready), 32'd1);
    bus.x       = x;
    bus.w       = w;
    bus.b       = b;
    bus.relu_en = relu;
    bus.start   = 1'b1;
    sb.push_back(e);
    base_cnt = valid_cnt;
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    bus.start   = 1'b0;
    bus.x       = N_IN'($urandom);
    bus.w       = {$urandom, $urandom};
    bus.b       = W_W'($urandom);
    bus.relu_en = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int lat);
    for (int i = 0; i < 60 && valid_cnt == base_cnt; i++) @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(valid_cnt - base_cnt), 32'd1);
    if (valid_cnt != base_cnt) chk({tag, "_latency"}, 32'(vq[$] - acc_cyc), 32'(lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN*W_W-1:0] wt;
    logic [N_IN-1:0]     xr;
    logic [W_W-1:0]      br;
    logic                rr;
    int                  b_idx;

    bus.en = 1'b1; bus.start = 1'b0; bus.x = '0; bus.w = '0; bus.b = '0; bus.relu_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_neuron", 32'(bus.neuron), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    start_op(8'hFF, rep(8'h40), 8'h00, 1'b1, mk(10'd512, 1'b0));
    wait_result("nominal", 9);

    start_op(8'h05, rep(8'h7F), 8'h7F, 1'b1, mk(10'd381, 1'b0));
    wait_result("sparse_bias", 9);

    wt = rep(8'h7F);
    wt[7:0] = 8'h80;
    start_op(8'h01, wt, 8'h00, 1'b1, mk(10'd0, 1'b0));
    wait_result("neg_relu", 9);
    start_op(8'h01, wt, 8'h00, 1'b0, mk(10'h380, 1'b0));
    wait_result("neg_linear", 9);

    start_op(8'hFF, rep(8'h7F), 8'h7F, 1'b1, mk(10'd1023, 1'b1));
    wait_result("sat_relu", 9);
    start_op(8'hFF, rep(8'h7F), 8'h7F, 1'b0, mk(10'd511, 1'b1));
    wait_result("sat_lin_pos", 9);
    start_op(8'hFF, rep(8'h80), 8'h80, 1'b0, mk(10'h200, 1'b1));
    wait_result("sat_lin_neg", 9);
    start_op(8'hFF, rep(8'h80), 8'h80, 1'b1, mk(10'd0, 1'b0));
    wait_result("neg_relu_big", 9);

    for (int i = 0; i < 4; i++) begin
      xr = N_IN'($urandom);
      wt = {$urandom, $urandom};
      br = W_W'($urandom);
      rr = 1'($urandom);
      start_op(xr, wt, br, rr, model(xr, wt, br, rr));
      wait_result("random", 9);
    end

    // start held high: one result every N_IN+2 cycles
    @(negedge clk);
    base_cnt = valid_cnt;
    b_idx    = vq.size();
    bus.x = 8'h05; bus.w = rep(8'h7F); bus.b = 8'h7F; bus.relu_en = 1'b1; bus.start = 1'b1;
    repeat (3) sb.push_back(mk(10'd381, 1'b0));
    @(posedge clk);
    #1 acc_cyc = cyc;
    repeat (29) @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 40 && valid_cnt < base_cnt + 3; i++) @(posedge clk);
    #1;
    chk("held_count", 32'(valid_cnt - base_cnt), 32'd3);
    if (vq.size() >= b_idx + 3) begin
      chk("held_first_latency", 32'(vq[b_idx] - acc_cyc), 32'd9);
      chk("held_spacing_1", 32'(vq[b_idx+1] - vq[b_idx]), 32'd10);
      chk("held_spacing_2", 32'(vq[b_idx+2] - vq[b_idx+1]), 32'd10);
    end

    // start pulsed mid-ACC while inputs are scrambled
    start_op(8'hFF, rep(8'h40), 8'h00, 1'b1, mk(10'd512, 1'b0));
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_result("start_ignored", 9);

    // start with en low in IDLE is not accepted
    @(negedge clk);
    base_cnt  = valid_cnt;
    bus.en    = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_low_idle_ready", 32'(bus.ready), 32'd1);
    bus.start = 1'b0;
    bus.en    = 1'b1;
    repeat (12) @(negedge clk);
    chk("en_low_no_valid", 32'(valid_cnt - base_cnt), 32'd0);

    // three disabled edges during ACC
    start_op(8'hFF, rep(8'h40), 8'h00, 1'b1, mk(10'd512, 1'b0));
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    wait_result("stall", 12);

    // reset in the middle of accumulation
    start_op(8'hFF, rep(8'h7F), 8'h7F, 1'b1, mk(10'd1023, 1'b1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    base_cnt = valid_cnt;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_neuron", 32'(bus.neuron), 32'd0);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", 32'(valid_cnt - base_cnt), 32'd0);
    start_op(8'hFF, rep(8'h40), 8'h00, 1'b1, mk(10'd512, 1'b0));
    wait_result("after_reset", 9);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
